// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ISA_WIDTH         : datapath / address width
//   RESET_PC_DEFAULT  : default PC after reset
//   IFU_* constants   : FSM state encoding (IFU_STATE_WIDTH bits)
//   pc_sel_e          : next-PC mux select for ifu_pc_reg
package ifu_fetch_pkg;

    localparam int ISA_WIDTH       = 32;
    localparam logic [ISA_WIDTH-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam int IFU_STATE_WIDTH = 2;
    localparam logic [IFU_STATE_WIDTH-1:0] IFU_REQ   = 2'd0;
    localparam logic [IFU_STATE_WIDTH-1:0] IFU_WAIT  = 2'd1;
    localparam logic [IFU_STATE_WIDTH-1:0] IFU_HOLD  = 2'd2;
    localparam logic [IFU_STATE_WIDTH-1:0] IFU_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/ifu_fetch_pc_reg.sv
// PC register with next-PC mux.
//   clk, rst_n      : clock, async active-low reset (loads RESET_PC)
//   sel_i           : hold / increment by PC_STEP / load redirect_pc_i
//   redirect_pc_i   : redirect target
//   pc_o            : current PC
//   pc_next_o       : value the PC takes at the next edge
module ifu_pc_reg
    import ifu_fetch_pkg::*;
#(
    parameter logic [ISA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned          PC_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  pc_sel_e              sel_i,
    input  logic [ISA_WIDTH-1:0] redirect_pc_i,
    output logic [ISA_WIDTH-1:0] pc_o,
    output logic [ISA_WIDTH-1:0] pc_next_o
);

    localparam logic [ISA_WIDTH-1:0] STEP = ISA_WIDTH'(PC_STEP);

    logic [ISA_WIDTH-1:0] pc_q;
    logic [ISA_WIDTH-1:0] pc_d;

    // Addition wraps modulo 2^ISA_WIDTH by construction.
    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PC_INC:   pc_d = pc_q + STEP;
            PC_REDIR: pc_d = redirect_pc_i;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding word fetch from imem, handing
// each instruction plus its PC to the decoder over valid/ready.
//   clk, rst                    : clock, async active-low reset
//   imem_req_valid/ready/addr   : read request (addr = pc)
//   imem_resp_valid/data/err    : read response, one per accepted request
//   inst_valid/ready, inst,
//   inst_pc, fetch_err          : instruction handoff to the decoder
//   redirect_valid/pc           : single-cycle redirect, flushes fetch
//
// state | meaning
// REQ   | request for pc presented to imem
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction (or fault) held for the decoder
// DRAIN | stale request outstanding, its response will be dropped
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [ISA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned          PC_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [ISA_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [ISA_WIDTH-1:0] imem_resp_data,
    input  logic                 imem_resp_err,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [ISA_WIDTH-1:0] inst,
    output logic [ISA_WIDTH-1:0] inst_pc,
    output logic                 fetch_err,
    input  logic                 redirect_valid,
    input  logic [ISA_WIDTH-1:0] redirect_pc
);

    logic [IFU_STATE_WIDTH-1:0] state_q, state_d, state_raw;
    logic [ISA_WIDTH-1:0]       inst_q, inst_d;
    logic [ISA_WIDTH-1:0]       inst_pc_q, inst_pc_d;
    logic                       err_q, err_d;
    logic [ISA_WIDTH-1:0]       pc;
    logic [ISA_WIDTH-1:0]       pc_next;
    pc_sel_e                    pc_sel;

    ifu_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst),
        .sel_i         (pc_sel),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc),
        .pc_next_o     (pc_next)
    );

    // Handshake-driven transitions and PC selection.
    always_comb begin
        state_raw = state_q;
        pc_sel    = PC_HOLD;
        unique case (state_q)
            IFU_REQ: begin
                if (redirect_valid) begin
                    pc_sel    = PC_REDIR;
                    state_raw = imem_req_ready ? IFU_DRAIN : IFU_REQ;
                end else if (imem_req_ready) begin
                    state_raw = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    pc_sel    = PC_REDIR;
                    state_raw = imem_resp_valid ? IFU_REQ : IFU_DRAIN;
                end else if (imem_resp_valid) begin
                    state_raw = IFU_HOLD;
                end
            end
            IFU_DRAIN: begin
                if (redirect_valid) pc_sel = PC_REDIR;
                if (imem_resp_valid) state_raw = IFU_REQ;
            end
            IFU_HOLD: begin
                // A redirect wins the PC even when a transfer happens too.
                if (redirect_valid) begin
                    pc_sel    = PC_REDIR;
                    state_raw = IFU_REQ;
                end else if (inst_ready) begin
                    pc_sel    = PC_INC;
                    state_raw = IFU_REQ;
                end
            end
            default: state_raw = IFU_REQ;
        endcase
    end

    // Instruction capture and the misaligned-PC shortcut. Kept separate from
    // the block above because it looks at pc_next, which depends on pc_sel.
    always_comb begin
        state_d   = state_raw;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        err_d     = err_q;
        if (state_q == IFU_WAIT && imem_resp_valid && !redirect_valid) begin
            inst_d    = imem_resp_err ? '0 : imem_resp_data;
            inst_pc_d = pc;
            err_d     = imem_resp_err;
        end
        // A misaligned PC never reaches memory: present a fault instead.
        if (state_raw == IFU_REQ && pc_next[1:0] != 2'b00) begin
            state_d   = IFU_HOLD;
            inst_d    = '0;
            inst_pc_d = pc_next;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IFU_REQ;
            inst_q    <= '0;
            inst_pc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
        end
    end

    // State sits in REQ during reset; gate so no request is seen then.
    assign imem_req_valid = (state_q == IFU_REQ) & rst;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state_q == IFU_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fetch_err       (fetch_err),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    typedef struct {
        logic        rq_rdy;
        logic        rs_v;
        logic [31:0] rs_d;
        logic        rs_e;
        logic        i_rdy;
        logic        rd_v;
        logic [31:0] rd_pc;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_in;
        logic [31:0] e_ipc;
        logic        e_fe;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rq, logic rsv, logic [31:0] rsd, logic rse,
                                logic ird, logic rdv, logic [31:0] rdpc,
                                logic erv, logic [31:0] era, logic eiv,
                                logic [31:0] ein, logic [31:0] eipc, logic efe);
        vec_t v;
        v.rq_rdy = rq;  v.rs_v = rsv; v.rs_d = rsd; v.rs_e = rse;
        v.i_rdy = ird;  v.rd_v = rdv; v.rd_pc = rdpc;
        v.e_rv = erv;   v.e_ra = era; v.e_iv = eiv;
        v.e_in = ein;   v.e_ipc = eipc; v.e_fe = efe;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rq, input logic rsv, input logic [31:0] rsd,
                         input logic rse, input logic ird, input logic rdv,
                         input logic [31:0] rdpc);
        imem_req_ready  = rq;
        imem_resp_valid = rsv;
        imem_resp_data  = rsd;
        imem_resp_err   = rse;
        inst_ready      = ird;
        redirect_valid  = rdv;
        redirect_pc     = rdpc;
    endtask

    task automatic check_all(input string tag, input logic erv, input logic [31:0] era,
                             input logic eiv, input logic [31:0] ein,
                             input logic [31:0] eipc, input logic efe);
        check({tag, ".req_valid"},  32'(imem_req_valid), 32'(erv));
        check({tag, ".req_addr"},   imem_req_addr, era);
        check({tag, ".inst_valid"}, 32'(inst_valid), 32'(eiv));
        check({tag, ".inst"},       inst, ein);
        check({tag, ".inst_pc"},    inst_pc, eipc);
        check({tag, ".fetch_err"},  32'(fetch_err), 32'(efe));
    endtask

    localparam logic [31:0] R = 32'h8000_0000;

    initial begin
        // Each row: inputs for this cycle, then outputs expected in this cycle
        // (before the clock edge that consumes the inputs).
        //   rq rsv rs_d          rse ird rdv rd_pc          rv ra             iv inst           inst_pc        fe
        // normal fetch at reset PC
        add(1, 0, 0,            0, 0, 0, 0,            1, R,             0, 0,             0,             0);
        add(0, 1, 32'h00000413, 0, 0, 0, 0,            0, R,             0, 0,             0,             0);
        add(0, 0, 0,            0, 1, 0, 0,            0, R,             1, 32'h00000413, R,             0);
        add(0, 0, 0,            0, 0, 0, 0,            1, R+4,           0, 32'h00000413, R,             0);
        // HOLD with inst_ready low for 5 cycles, memory ready but no request
        add(1, 0, 0,            0, 0, 0, 0,            1, R+4,           0, 32'h00000413, R,             0);
        add(0, 1, 32'h00A00093, 0, 0, 0, 0,            0, R+4,           0, 32'h00000413, R,             0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 0,        0, 0, 0, 0,            0, R+4,           1, 32'h00A00093, R+4,           0);
        add(0, 0, 0,            0, 1, 0, 0,            0, R+4,           1, 32'h00A00093, R+4,           0);
        add(0, 0, 0,            0, 1, 0, 0,            1, R+8,           0, 32'h00A00093, R+4,           0);
        // access fault at R+8, next fetch clears fetch_err
        add(1, 0, 0,            0, 0, 0, 0,            1, R+8,           0, 32'h00A00093, R+4,           0);
        add(0, 1, 32'hDEADBEEF, 1, 0, 0, 0,            0, R+8,           0, 32'h00A00093, R+4,           0);
        add(0, 0, 0,            0, 1, 0, 0,            0, R+8,           1, 0,             R+8,           1);
        add(1, 0, 0,            0, 0, 0, 0,            1, R+12,          0, 0,             R+8,           1);
        add(0, 1, 32'h00100113, 0, 0, 0, 0,            0, R+12,          0, 0,             R+8,           1);
        add(0, 0, 0,            0, 0, 0, 0,            0, R+12,          1, 32'h00100113, R+12,          0);
        add(0, 0, 0,            0, 1, 0, 0,            0, R+12,          1, 32'h00100113, R+12,          0);
        // redirect in WAIT, stale response 3 cycles later is dropped
        add(1, 0, 0,            0, 0, 0, 0,            1, R+16,          0, 32'h00100113, R+12,          0);
        add(0, 0, 0,            0, 0, 1, R+32'h100,    0, R+16,          0, 32'h00100113, R+12,          0);
        add(0, 0, 0,            0, 0, 0, 0,            0, R+32'h100,     0, 32'h00100113, R+12,          0);
        add(0, 0, 0,            0, 0, 0, 0,            0, R+32'h100,     0, 32'h00100113, R+12,          0);
        add(0, 1, 32'hBADBAD00, 0, 0, 0, 0,            0, R+32'h100,     0, 32'h00100113, R+12,          0);
        add(1, 0, 0,            0, 0, 0, 0,            1, R+32'h100,     0, 32'h00100113, R+12,          0);
        add(0, 1, 32'h00000013, 0, 0, 0, 0,            0, R+32'h100,     0, 32'h00100113, R+12,          0);
        // misaligned redirect from HOLD: fault without a memory request
        add(0, 0, 0,            0, 0, 1, R+32'h102,    0, R+32'h100,     1, 32'h00000013, R+32'h100,     0);
        add(1, 0, 0,            0, 0, 0, 0,            0, R+32'h102,     1, 0,             R+32'h102,     1);
        add(1, 0, 0,            0, 0, 1, R+32'h200,    0, R+32'h102,     1, 0,             R+32'h102,     1);
        add(1, 0, 0,            0, 0, 0, 0,            1, R+32'h200,     0, 0,             R+32'h102,     1);
        add(0, 1, 32'h00000073, 0, 0, 0, 0,            0, R+32'h200,     0, 0,             R+32'h102,     1);
        add(0, 0, 0,            0, 1, 0, 0,            0, R+32'h200,     1, 32'h00000073, R+32'h200,     0);
        // redirect in REQ while memory not ready: address changes under valid
        add(0, 0, 0,            0, 0, 1, R+32'h300,    1, R+32'h204,     0, 32'h00000073, R+32'h200,     0);
        add(0, 0, 0,            0, 0, 0, 0,            1, R+32'h300,     0, 32'h00000073, R+32'h200,     0);
        // PC wrap from FFFF_FFFC to 0
        add(0, 0, 0,            0, 0, 1, 32'hFFFFFFFC, 1, R+32'h300,     0, 32'h00000073, R+32'h200,     0);
        add(1, 0, 0,            0, 0, 0, 0,            1, 32'hFFFFFFFC,  0, 32'h00000073, R+32'h200,     0);
        add(0, 1, 32'h11111111, 0, 0, 0, 0,            0, 32'hFFFFFFFC,  0, 32'h00000073, R+32'h200,     0);
        add(0, 0, 0,            0, 1, 0, 0,            0, 32'hFFFFFFFC,  1, 32'h11111111, 32'hFFFFFFFC,  0);
        add(0, 0, 0,            0, 0, 0, 0,            1, 32'h00000000,  0, 32'h11111111, 32'hFFFFFFFC,  0);

        // reset state
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check_all("reset", 0, R, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rq_rdy, vecs[i].rs_v, vecs[i].rs_d, vecs[i].rs_e,
                  vecs[i].i_rdy, vecs[i].rd_v, vecs[i].rd_pc);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_ra,
                      vecs[i].e_iv, vecs[i].e_in, vecs[i].e_ipc, vecs[i].e_fe);
        end

        // async reset while in WAIT, then a late stale response is ignored
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_all("async_rst", 0, R, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 32'hCAFEF00D, 0, 0, 0, 0);
        #1;
        check_all("post_rst_req", 1, R, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        check_all("stale_ignored", 1, R, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 32'h00000493, 0, 0, 0, 0);
        #1;
        check_all("post_rst_wait", 0, R, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all("post_rst_hold", 0, R, 1, 32'h00000493, R, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit: holds the PC, issues word reads to instruction memory over a valid/ready request and response interface, and presents each fetched instruction with its PC to the IDU through a valid/ready handshake. It sits directly upstream of the IDU decoders, and its inst output feeds opcode/funct3/funct7 decode. A downstream redirect (branch/jump/trap target) flushes in-flight or held fetches.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
PC_STEP, 4, sequential PC increment after each instruction handoff.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
imem_req_valid  out  1  read request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  `ISA_WIDTH  read address (= pc).
imem_resp_valid  in  1  read data valid (one pulse per accepted request).
imem_resp_data  in  `ISA_WIDTH  instruction word.
imem_resp_err  in  1  access fault for this response.
inst_valid  out  1  instruction available to IDU.
inst_ready  in  1  IDU accepts instruction.
inst  out  `ISA_WIDTH  instruction word.
inst_pc  out  `ISA_WIDTH  PC of inst.
fetch_err  out  1  inst is a fault (access fault or misaligned PC).
redirect_valid  in  1  single-cycle redirect pulse.
redirect_pc  in  `ISA_WIDTH  redirect target.

Behaviour:
- Reset (rst=0, async): state=REQ, pc=RESET_PC, inst=0, inst_pc=0, fetch_err=0, inst_valid=0, imem_req_valid=0 during reset.
- States: REQ, WAIT, HOLD, DRAIN. Outputs are registered or decoded from state only. There is no combinational path from inst_ready/redirect_valid to any output.
- REQ: imem_req_valid=1, imem_req_addr=pc.
  - req_ready & !redirect -> WAIT.
  - redirect & req_ready -> pc<=redirect_pc, DRAIN (the stale request was accepted).
  - redirect & !req_ready -> pc<=redirect_pc, stay REQ. This is the only case where imem_req_addr changes while imem_req_valid is held.
- WAIT:
  - resp_valid & !redirect -> inst<=resp_err?0:resp_data, inst_pc<=pc, fetch_err<=resp_err, HOLD.
  - resp_valid & redirect -> discard, pc<=redirect_pc, REQ.
  - redirect & !resp_valid -> pc<=redirect_pc, DRAIN.
- DRAIN: the response is discarded when it arrives -> REQ. A redirect in DRAIN updates pc and stays in DRAIN.
- HOLD: inst_valid=1. inst, inst_pc and fetch_err are stable until transfer.
  - inst_valid & inst_ready -> transfer, pc<=pc+PC_STEP, REQ.
  - redirect (with or without ready) -> pc<=redirect_pc, REQ. If ready was also high, the transfer still counts.
- Misaligned target: the redirect_pc[1:0]!=0 check happens on entering REQ. No memory request is issued. Go directly to HOLD with inst=0, inst_pc=pc, fetch_err=1.
- PC arithmetic is modulo 2^`ISA_WIDTH; 32'hFFFF_FFFC+4 wraps to 0 silently.
- At most one outstanding memory request. Throughput is at best one instruction per 3 cycles (REQ, WAIT, HOLD); no prefetch.

Decomposition:
- config.vh: `ISA_WIDTH, RESET_PC default.
- ifu.vh: state encoding constants (IFU_REQ, IFU_WAIT, IFU_HOLD, IFU_DRAIN), IFU_STATE_WIDTH=2.
- One sub-module, ifu_pc_reg: PC register with async active-low reset to RESET_PC and a next-PC mux (hold / +PC_STEP / redirect_pc).

Test Plan:
1. Release reset, memory ready=1, resp 1 cycle later with 32'h00000413 -> imem_req_addr=32'h8000_0000; inst_valid with inst=32'h00000413, inst_pc=32'h8000_0000; after ready, next addr=32'h8000_0004.
2. Hold inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, no new imem_req_valid. Then ready=1 -> exactly one transfer.
3. Redirect to 32'h8000_0100 while in WAIT; stale resp arrives 3 cycles later -> stale data never appears on inst; next request addr=32'h8000_0100.
4. imem_resp_err=1 on fetch at 32'h8000_0008 -> inst=0, fetch_err=1, inst_pc=32'h8000_0008. The next fetch clears fetch_err.
5. Redirect to 32'h8000_0102 -> no imem_req_valid; HOLD with fetch_err=1, inst_pc=32'h8000_0102.
6. Assert rst=0 mid-WAIT, asynchronously -> outputs reset immediately. After release, the first request is to 32'h8000_0000, and any late stale response is ignored.
